composite_pattern_gen: RTL

Parametrised 2-bit composite video timing and test-pattern generator for the 8bit display path. It divides the system clock down to a pixel rate and generates horizontal and vertical timing with programmable porches and sync widths. It drives a 4-level composite output (SYNC/BLACK/GRAY/WHITE) from one of four selectable test patterns, and counts frames for animation. It replaces the fixed top-level pattern logic and the free-running clock-halving flop.

---
 rtl/composite_pattern_gen_if.sv | 24 ++
 rtl/composite_pattern_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/composite_pattern_gen_if.sv
// Bundle of the composite generator's mode input and timing/level outputs.
interface composite_pattern_gen_if #(
    parameter int unsigned POS_W = 9
);
    logic [1:0]       mode;
    logic [1:0]       out;
    logic             hsync;
    logic             vsync;
    logic             display_on;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic [7:0]       frame;
    logic             pix_en;

    modport master (
        input  mode,
        output out, hsync, vsync, display_on, hpos, vpos, frame, pix_en
    );

    modport slave (
        output mode,
        input  out, hsync, vsync, display_on, hpos, vpos, frame, pix_en
    );
endinterface

// File: rtl/composite_pattern_gen.sv
// Composite video timing plus 4-level test-pattern generator with a pixel-rate
// divider; all outputs registered and updated together after each pixel strobe.
module composite_pattern_gen #(
    parameter int unsigned H_DISPLAY = 256,
    parameter int unsigned H_BACK    = 60,
    parameter int unsigned H_FRONT   = 40,
    parameter int unsigned H_SYNC    = 25,
    parameter int unsigned V_DISPLAY = 240,
    parameter int unsigned V_TOP     = 18,
    parameter int unsigned V_BOTTOM  = 14,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned POS_W     = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    composite_pattern_gen_if.master vid
);
    localparam int unsigned H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_MAX = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_MAX - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_MAX - 1);
    localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] H_EDGE   = POS_W'(H_DISPLAY - 1);
    localparam logic [POS_W-1:0] V_EDGE   = POS_W'(V_DISPLAY - 1);
    localparam logic [POS_W-1:0] BAND1    = POS_W'(V_DISPLAY / 3);
    localparam logic [POS_W-1:0] BAND2    = POS_W'(2 * V_DISPLAY / 3);

    localparam logic [1:0] LVL_SYNC  = 2'd0;
    localparam logic [1:0] LVL_BLACK = 2'd1;
    localparam logic [1:0] LVL_GRAY  = 2'd2;
    localparam logic [1:0] LVL_WHITE = 2'd3;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_n;
    logic [DIV_W-1:0] r_div, w_div_n;
    logic             r_pix_en;
    logic [POS_W-1:0] r_hpos, r_vpos, w_hpos_n, w_vpos_n;
    logic [7:0]       r_frame, w_frame_n;
    logic [1:0]       r_mode, w_mode_n;
    logic             r_hsync, r_vsync, r_disp;
    logic [1:0]       r_out;
    logic             w_hsync_n, w_vsync_n, w_disp_n, w_r;
    logic [2:0]       w_plaid_sum;
    logic [1:0]       w_pat, w_out_n;

    assign w_div_n = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_n;
    end

    // Position/frame sequencing; mode is sampled only when a frame begins
    always_comb begin
        w_state_n = r_state;
        w_hpos_n  = r_hpos;
        w_vpos_n  = r_vpos;
        w_frame_n = r_frame;
        w_mode_n  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (r_pix_en) begin
                    w_state_n = S_RUN;
                    w_hpos_n  = '0;
                    w_vpos_n  = '0;
                    w_mode_n  = vid.mode;
                end
            end
            S_RUN: begin
                if (r_pix_en) begin
                    if (r_hpos == H_LAST) begin
                        w_hpos_n = '0;
                        if (r_vpos == V_LAST) begin
                            w_vpos_n  = '0;
                            w_frame_n = r_frame + 8'd1;
                            w_mode_n  = vid.mode;
                        end else begin
                            w_vpos_n = r_vpos + POS_W'(1);
                        end
                    end else begin
                        w_hpos_n = r_hpos + POS_W'(1);
                    end
                end
            end
        endcase
    end

    // Decode on the upcoming position so level and sync track hpos/vpos exactly
    always_comb begin
        w_hsync_n   = (w_hpos_n >= HS_FIRST) && (w_hpos_n <= HS_LAST);
        w_vsync_n   = (w_vpos_n >= VS_FIRST) && (w_vpos_n <= VS_LAST);
        w_disp_n    = (w_hpos_n < H_VIS) && (w_vpos_n < V_VIS);
        w_r         = (w_hpos_n[2:0] == 3'd0) || (w_vpos_n[2:0] == 3'd0);
        w_plaid_sum = 3'd1 + 3'(w_r) + 3'(w_vpos_n[4]) + 3'(w_hpos_n[4]);
        w_pat       = LVL_BLACK;
        case (w_mode_n)
            2'd0: w_pat = (w_plaid_sum > 3'd3) ? LVL_WHITE : w_plaid_sum[1:0];
            2'd1: w_pat = (w_vpos_n < BAND1) ? LVL_GRAY :
                          (w_vpos_n < BAND2) ? LVL_WHITE : LVL_BLACK;
            2'd2: w_pat = ((w_hpos_n == '0) || (w_hpos_n == H_EDGE) ||
                           (w_vpos_n == '0) || (w_vpos_n == V_EDGE)) ? LVL_WHITE : LVL_BLACK;
            default: w_pat = (w_hpos_n[POS_W-1:3] == w_frame_n[POS_W-4:0]) ? LVL_WHITE : LVL_GRAY;
        endcase
        w_out_n = (w_hsync_n || w_vsync_n) ? LVL_SYNC :
                  (!w_disp_n)              ? LVL_BLACK : w_pat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
            r_hpos   <= '0;
            r_vpos   <= '0;
            r_frame  <= '0;
            r_mode   <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_disp   <= 1'b0;
            r_out    <= LVL_SYNC;
        end else begin
            r_div    <= w_div_n;
            r_pix_en <= (r_div == DIV_LAST);
            if (r_pix_en) begin
                r_hpos  <= w_hpos_n;
                r_vpos  <= w_vpos_n;
                r_frame <= w_frame_n;
                r_mode  <= w_mode_n;
                r_hsync <= w_hsync_n;
                r_vsync <= w_vsync_n;
                r_disp  <= w_disp_n;
                r_out   <= w_out_n;
            end
        end
    end

    assign vid.out        = r_out;
    assign vid.hsync      = r_hsync;
    assign vid.vsync      = r_vsync;
    assign vid.display_on = r_disp;
    assign vid.hpos       = r_hpos;
    assign vid.vpos       = r_vpos;
    assign vid.frame      = r_frame;
    assign vid.pix_en     = r_pix_en;
endmodule
